// File: rtl/pixel_proc_pkg.sv
// Shared op codes, luma weights and FSM encoding for the pixel stream processor.
package pixel_proc_pkg;

   localparam logic [2:0] OP_PASS   = 3'b000;
   localparam logic [2:0] OP_GRAY   = 3'b001;
   localparam logic [2:0] OP_THRESH = 3'b010;
   localparam logic [2:0] OP_BRIGHT = 3'b011;
   localparam logic [2:0] OP_DARK   = 3'b100;
   localparam logic [2:0] OP_INVERT = 3'b101;

   localparam int LUMA_R = 77;
   localparam int LUMA_G = 150;
   localparam int LUMA_B = 29;

   typedef enum logic {
      ST_WAIT_SOF = 1'b0,
      ST_ACTIVE   = 1'b1
   } state_t;

endpackage

// File: rtl/pixel_op_unit.sv
// Single-channel arithmetic: saturating add/subtract of an operand, and bitwise invert.
module pixel_op_unit #(
   parameter int PIX_W = 8
) (
   input  logic [PIX_W-1:0] pix,
   input  logic [PIX_W-1:0] operand,
   output logic [PIX_W-1:0] add_sat,
   output logic [PIX_W-1:0] sub_sat,
   output logic [PIX_W-1:0] inv
);

   logic [PIX_W:0] sum;
   logic [PIX_W:0] diff;

   assign sum  = {1'b0, pix} + {1'b0, operand};
   assign diff = {1'b0, pix} - {1'b0, operand};

   // Carry out means overflow; borrow out means underflow.
   assign add_sat = sum[PIX_W]  ? '1 : sum[PIX_W-1:0];
   assign sub_sat = diff[PIX_W] ? '0 : diff[PIX_W-1:0];
   assign inv     = ~pix;

endmodule

// File: rtl/pixel_stream_processor.sv
// Valid/ready pixel stream processor: SOF-latched per-pixel op, 2-stage pipeline, frame geometry tracking.
//   state       | meaning
//   ST_WAIT_SOF | idle between frames; non-SOF beats are dropped and flag an error
//   ST_ACTIVE   | inside a frame; beats forwarded, col/row follow geometry
module pixel_stream_processor
   import pixel_proc_pkg::*;
#(
   parameter int PIX_W    = 8,
   parameter int CHANNELS = 3,
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                operation_select,
   input  logic [PIX_W-1:0]          threshold_value,
   input  logic [PIX_W-1:0]          brightness_value,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [CHANNELS*PIX_W-1:0] s_data,
   input  logic                      s_sof,
   input  logic                      s_eol,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [CHANNELS*PIX_W-1:0] m_data,
   output logic                      m_sof,
   output logic                      m_eol,
   output logic                      frame_done,
   output logic                      frame_err
);

   localparam int DW = CHANNELS * PIX_W;
   localparam int LW = PIX_W + 8;
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d, beat_col;
   logic [RW-1:0]     row_q, row_d, beat_row;
   logic              err_d, latch_cfg, fwd, last_col, last_row;
   logic [2:0]        op_q, op_eff;
   logic [PIX_W-1:0]  thr_q, thr_eff, bri_q, bri_eff;
   logic              advance, accept;

   assign advance = !m_valid | m_ready;
   assign s_ready = !rst & ((state_q == ST_WAIT_SOF & !s_sof) | advance);
   assign accept  = s_valid & s_ready;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      err_d     = frame_err;
      latch_cfg = 1'b0;
      fwd       = 1'b0;
      beat_col  = col_q;
      beat_row  = row_q;
      last_col  = 1'b0;
      last_row  = 1'b0;
      if (accept) begin
         if (state_q == ST_WAIT_SOF && !s_sof) begin
            err_d = 1'b1;
         end else begin
            fwd = 1'b1;
            if (s_sof) begin
               // A restart anywhere but (0,0) is itself a framing error.
               latch_cfg = 1'b1;
               err_d     = (state_q == ST_ACTIVE) && (col_q != '0 || row_q != '0);
               beat_col  = '0;
               beat_row  = '0;
            end
            last_col = (beat_col == COL_LAST);
            last_row = (beat_row == ROW_LAST);
            if (s_eol != last_col) err_d = 1'b1;
            state_d = ST_ACTIVE;
            if (last_col) begin
               col_d = '0;
               if (last_row) begin
                  row_d   = '0;
                  state_d = ST_WAIT_SOF;
               end else begin
                  row_d = beat_row + ROW_ONE;
               end
            end else begin
               col_d = beat_col + COL_ONE;
               row_d = beat_row;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_WAIT_SOF;
         col_q     <= '0;
         row_q     <= '0;
         frame_err <= 1'b0;
         op_q      <= OP_PASS;
         thr_q     <= '0;
         bri_q     <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         frame_err <= err_d;
         if (latch_cfg) begin
            op_q  <= operation_select;
            thr_q <= threshold_value;
            bri_q <= brightness_value;
         end
      end
   end

   // The SOF beat itself must use the freshly presented config.
   assign op_eff  = latch_cfg ? operation_select : op_q;
   assign thr_eff = latch_cfg ? threshold_value  : thr_q;
   assign bri_eff = latch_cfg ? brightness_value : bri_q;

   logic [PIX_W-1:0] luma;
   generate
      if (CHANNELS == 3) begin : g_luma_rgb
         logic [LW-1:0] r_ext, g_ext, b_ext, acc;
         assign r_ext = LW'(s_data[2*PIX_W +: PIX_W]);
         assign g_ext = LW'(s_data[PIX_W +: PIX_W]);
         assign b_ext = LW'(s_data[0 +: PIX_W]);
         assign acc   = r_ext * LW'(LUMA_R) + g_ext * LW'(LUMA_G) + b_ext * LW'(LUMA_B);
         assign luma  = acc[LW-1:8];
      end else begin : g_luma_mono
         assign luma = s_data[PIX_W-1:0];
      end
   endgenerate

   logic [DW-1:0] add_v, sub_v, inv_v;
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      pixel_op_unit #(.PIX_W(PIX_W)) u_op (
         .pix     (s_data[c*PIX_W +: PIX_W]),
         .operand (bri_eff),
         .add_sat (add_v[c*PIX_W +: PIX_W]),
         .sub_sat (sub_v[c*PIX_W +: PIX_W]),
         .inv     (inv_v[c*PIX_W +: PIX_W])
      );
   end

   logic              s1_valid, s1_sof, s1_eol, s1_last, m_last;
   logic [DW-1:0]     s1_data, s1_add, s1_sub, s1_inv, mux_data;
   logic [PIX_W-1:0]  s1_luma, s1_thr;
   logic [2:0]        s1_op;

   always_comb begin
      mux_data = s1_data;
      case (s1_op)
         OP_GRAY:   mux_data = {CHANNELS{s1_luma}};
         OP_THRESH: mux_data = (s1_luma >= s1_thr) ? '1 : '0;
         OP_BRIGHT: mux_data = s1_add;
         OP_DARK:   mux_data = s1_sub;
         OP_INVERT: mux_data = s1_inv;
         default:   mux_data = s1_data;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_add   <= '0;
         s1_sub   <= '0;
         s1_inv   <= '0;
         s1_luma  <= '0;
         s1_thr   <= '0;
         s1_op    <= OP_PASS;
         s1_sof   <= 1'b0;
         s1_eol   <= 1'b0;
         s1_last  <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_sof    <= 1'b0;
         m_eol    <= 1'b0;
         m_last   <= 1'b0;
      end else if (advance) begin
         s1_valid <= fwd;
         if (fwd) begin
            s1_data <= s_data;
            s1_add  <= add_v;
            s1_sub  <= sub_v;
            s1_inv  <= inv_v;
            s1_luma <= luma;
            s1_thr  <= thr_eff;
            s1_op   <= op_eff;
            s1_sof  <= (beat_col == '0) && (beat_row == '0);
            s1_eol  <= last_col;
            s1_last <= last_col & last_row;
         end
         m_valid <= s1_valid;
         if (s1_valid) begin
            m_data <= mux_data;
            m_sof  <= s1_sof;
            m_eol  <= s1_eol;
            m_last <= s1_last;
         end
      end
   end

   assign frame_done = m_valid & m_ready & m_last;

endmodule

// File: doc/pixel_stream_processor.md
# pixel_stream_processor

Streaming, parametrised successor to the frame-level image processor. It applies one of six per-pixel operations to a valid/ready pixel stream carrying CHANNELS×PIX_W bits per beat. The operation and its operands are latched at each start-of-frame, and the block tracks frame geometry, flagging framing errors. It sits between the pixel source (memory reader or camera front-end) and the frame sink, sustaining one pixel per clock.

## Interface
- PIX_W, 8, bits per channel
- CHANNELS, 3, channels per pixel (1 or 3; 3 = R,G,B with R in MSBs)
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- operation_select  in  3  op code, sampled at accepted SOF
- threshold_value  in  PIX_W  threshold operand, sampled at SOF
- brightness_value  in  PIX_W  brightness operand, sampled at SOF
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid&s_ready
- s_data  in  CHANNELS*PIX_W  input pixel
- s_sof  in  1  first pixel of frame
- s_eol  in  1  last pixel of line
- m_valid  out  1  output beat valid
- m_ready  in  1  sink ready
- m_data  out  CHANNELS*PIX_W  processed pixel
- m_sof, m_eol  out  1 each  markers delayed with their pixel
- frame_done  out  1  one-cycle pulse when last pixel of frame leaves m_*
- frame_err  out  1  sticky; set on framing error, cleared at next accepted SOF

## Operation
- Ops (latched copy used for whole frame): 000 pass; 001 grayscale (luma replicated to all channels); 010 threshold (luma >= threshold_value → all-ones pixel, else zero); 011 brighten (per-channel saturating add, clamp 2^PIX_W−1); 100 darken (per-channel saturating subtract, clamp 0); 101 invert (~channel); 110/111 pass.
- Luma = (77·R + 150·G + 29·B) >> 8, computed in PIX_W+8 bits, truncated to PIX_W. For CHANNELS=1, luma = channel 0 and grayscale = pass.
- FSM states: WAIT_SOF, ACTIVE.
  - WAIT_SOF: s_ready=1. Beats without s_sof are dropped (not forwarded) and set frame_err. An accepted beat with s_sof latches the config, clears frame_err, sets col=0/row=0, and goes to ACTIVE; that beat is processed.
  - ACTIVE: each accepted beat increments col. At col==IMG_W−1, s_eol is expected; col←0 and row++. s_eol at any other col, or a missing s_eol at IMG_W−1, sets frame_err while counters follow geometry, not markers. The beat at row==IMG_H−1, col==IMG_W−1 returns to WAIT_SOF.
  - s_sof in ACTIVE at a position other than (0,0): frame_err set, then treated as a new frame (relatch config, counters reset, frame_err then re-set for this event only), and the pixel is forwarded.
- Output m_sof/m_eol come from the counters (geometry-correct), not echoed from the inputs.

## Timing
- 2-stage pipeline. Stage 1 registers luma and the saturating sums; stage 2 registers the op mux.
- Latency is 2 cycles from acceptance to m_valid with no stall. Throughput is 1 beat/clock.
- Global stall: advance = !m_valid | m_ready. s_ready = advance in ACTIVE, 1 in WAIT_SOF for dropped beats, and 0 while rst is asserted.
- m_data, m_sof and m_eol stay stable while m_valid & !m_ready.
- frame_done is asserted in the cycle the final beat handshakes on m_*.
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, frame_done=0, frame_err=0, state=WAIT_SOF, counters=0, latched op=000.
- Reset mid-frame discards pipeline contents with no partial output.
- A config change during ACTIVE has no effect until the next SOF.

## Structure
- Package pixel_proc_pkg holds the op-code localparams (OP_PASS…OP_INVERT), the luma coefficients and the FSM state encoding.
- One sub-module, pixel_op_unit: a per-channel saturating add/sub/invert, instantiated CHANNELS times with a generate loop.
- Top module contains the FSM, counters, config latch, luma and pipeline registers.

## Test plan
- IMG_W=4, IMG_H=2, op 011, brightness 80, pixel channels 200/10/0 → output 255/90/80, latency 2, frame_done once after 8 beats.
- Op 010, threshold 128, pixels (128,128,128) and (127,127,127) → all-ones then all-zeros.
- Random m_ready (50%) over a full frame with op 101 → output equals ~input in order, no loss or duplication, data held during stalls.
- Two beats without SOF, then SOF → both dropped, frame_err=1, then cleared at SOF; s_eol at col 1 → frame_err set, m_eol still at col 3.
- Change operation_select mid-frame from 000 to 101 → current frame passes unchanged, next frame is inverted.
- Assert rst mid-frame with m_valid high → m_valid=0 immediately, state WAIT_SOF, next frame processed normally.
